// File: rtl/mem_access_ctrl.sv
// Multi-cycle data-memory access controller with req/ack handshake, timeout and sticky error.
// Define MEM_HIT_BUF_EN to add a one-entry read buffer that lets repeat loads complete stall-free.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic [31:0] m_rdata_i,
  input  logic        m_ack_i
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [15:0] CntSat = 16'(TIMEOUT);
  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic        op;
  logic        hit;
  logic [31:0] buf_rdata;
  logic        unused_addr_bits;

  assign op = mem_re_i | mem_we_i;
  assign unused_addr_bits = ^addr_i[1:0];

`ifdef MEM_HIT_BUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [29:0] buf_tag_q, buf_tag_d;
  logic [31:0] buf_data_q, buf_data_d;

  assign hit = (state_q == StIdle) && mem_re_i && !mem_we_i && buf_valid_q &&
               (buf_tag_q == addr_i[31:2]);
  assign buf_rdata = buf_data_q;

  // Only acked accesses touch the buffer; timed-out ones leave it as is.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    if (state_q == StReq && m_ack_i) begin
      if (!m_we_q) begin
        buf_valid_d = 1'b1;
        buf_tag_d   = m_addr_q[31:2];
        buf_data_d  = m_rdata_i;
      end else if (buf_valid_q && buf_tag_q == m_addr_q[31:2]) begin
        buf_data_d  = m_wdata_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign hit       = 1'b0;
  assign buf_rdata = '0;
`endif

  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    done_o    = 1'b0;
    case (state_q)
      StIdle: begin
        done_o = !op || hit;
        if (op && !hit) begin
          m_req_d   = 1'b1;
          m_we_d    = mem_we_i;
          m_addr_d  = {addr_i[31:2], 2'b00};
          m_wdata_d = wdata_i;
          cnt_d     = '0;
          state_d   = StReq;
        end
      end
      StReq: begin
        cnt_d = (cnt_q >= CntSat) ? cnt_q : cnt_q + 16'd1;
        // Ack is checked first so an ack on the last allowed cycle still succeeds.
        if (m_ack_i) begin
          rdata_d = m_rdata_i;
          m_req_d = 1'b0;
          state_d = StDone;
        end else if (cnt_q >= CntLast) begin
          err_d   = 1'b1;
          rdata_d = '0;
          m_req_d = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rdata_o   = hit ? buf_rdata : rdata_q;
  assign err_o     = err_q;
  assign m_req_o   = m_req_q;
  assign m_we_o    = m_we_q;
  assign m_addr_o  = m_addr_q;
  assign m_wdata_o = m_wdata_q;

endmodule
